ir_encoder: RTL and testbench
=============================

# ir_encoder

NEC-protocol infrared transmitter, the transmit-side counterpart of the IR decoder. Accepts a 32-bit command word, or a repeat request, through a start/busy/done handshake. Emits the NEC pulse train as an unmodulated envelope, an active-low receiver-style level, and an optionally 38 kHz-modulated LED drive. The frame it produces, looped into the decoder, yields `ready` with the identical 32-bit `command`.

## Interface

Parameters:

- `UNIT_CYCLES`, 14063 — clocks per NEC unit (562.5 µs at 25 MHz).
- `CARRIER_HALF`, 329 — clocks per carrier half-period (≈38 kHz at 25 MHz).
- `MODULATE`, 1 — 1: `ir_out` carries the carrier during marks; 0: `ir_out` equals `ir_env`.

Ports:

- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1 — system clock.
  - `rst` in 1 — synchronous, active-high reset.
- `enable` in 1 — while low: no start accepted; an in-progress frame aborts.
- `start` in 1 — request a transmission; sampled only in IDLE.
- `repeat_req` in 1 — sampled with `start`; 1 sends a repeat frame and ignores `command`.
- `command` in 32 — payload, latched on accept, sent LSB first.
- `busy` out 1 — high from the cycle after accept until frame period end.
- `done` out 1 — one-cycle pulse at normal frame completion.
- `ir_env` out 1 — envelope, 1 = mark.
- `ir_rx_level` out 1 — `~ir_env`; idle high, same as a demodulating receiver output.
- `ir_out` out 1 — LED drive.

## Operation

- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GUARD.
- Accept: `start & enable` in IDLE latches `command` into the shift register and `repeat_req` into the mode flag, then enters LEAD_MARK.
- Phase lengths, in units:
  - LEAD_MARK 16.
  - LEAD_SPACE 8 for data, 4 for repeat; repeat proceeds directly to STOP_MARK.
  - BIT_MARK 1.
  - BIT_SPACE 1 for bit value 0, 3 for bit value 1.
  - STOP_MARK 1.
- Bits: shift register LSB is sent, then shifted right. A 6-bit bit counter moves to STOP_MARK after the 32nd BIT_SPACE.
- GUARD: envelope low until the frame counter reaches FRAME_UNITS = 192 (108 ms), measured from the first LEAD_MARK cycle. Then return to IDLE with `done`=1.
- Frame counter: 8 bits. Worst-case active length is 153 units, so it never wraps.
- Carrier: phase counter restarts at every mark entry, so each mark begins with `ir_out`=1. It toggles every CARRIER_HALF clocks while in a mark. `ir_out`=0 outside marks.
- Abort: `enable` low in any non-IDLE state. Next cycle: IDLE, `ir_env`=0, `busy`=0, no `done`.
- `start` while busy: ignored, not queued.

## Timing

- Reset values:
  - `busy`=0, `done`=0, `ir_env`=0, `ir_rx_level`=1, `ir_out`=0.
  - State IDLE; all counters 0.
- All outputs are registered.
- Accept edge → `ir_env`=1 and `busy`=1 on the next cycle (latency 1).
- Each phase lasts exactly N·UNIT_CYCLES cycles; no gap cycles between phases.
- From the first mark cycle to the `done` cycle: exactly 192·UNIT_CYCLES cycles, for both data and repeat frames.
- Done/busy handover: `done`=1 in the same cycle `busy` returns to 0. A `start` sampled at that cycle's closing edge is accepted, giving back-to-back frames.
- `rst` mid-frame: next cycle equals the reset state.

## Structure

- Package `ir_nec_pkg`:
  - State enum.
  - Unit constants: LEAD_MARK_U=16, LEAD_SPACE_U=8, REPEAT_SPACE_U=4, BIT_ONE_SPACE_U=3, FRAME_UNITS=192, NEC_BITS=32.
  - Default UNIT_CYCLES and CARRIER_HALF.
- The decoder's future refactor uses the same package.
- Sub-module `ir_carrier_gen`: carrier phase counter with `restart` and `run` inputs and output `carrier`.

## Test plan

- UNIT_CYCLES=10, `command`=32'h00FF_A25D → `ir_env` sequence:
  - 160 high, 80 low.
  - First bit 1 (10 high / 30 low), second bit 0 (10/10), … 32 bits LSB first.
  - 10 high stop.
  - `done` at cycle 1920 after the first mark cycle.
- UNIT_CYCLES=10, `repeat_req`=1 → 160 high, 40 low, 10 high, then low; `busy` for 1920 cycles; `done` once.
- `command`=0 → 32 pairs of 10/10; last falling envelope edge 890 cycles after frame start.
- `start` pulsed mid-frame → ignored. `start` held through the `done` cycle → second frame's mark begins the very next cycle.
- `enable` dropped during BIT_SPACE → next cycle `busy`=0, `ir_env`=0; no `done` ever.
- Default parameters, `ir_rx_level` fed to the decoder, `command`=32'hDEAD_BEEF → decoder `ready`=1 and decoder `command`=32'hDEAD_BEEF. With `MODULATE`=1, `ir_out` toggles every 329 cycles inside each mark and stays 0 in spaces.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared NEC infrared definitions: FSM states, phase lengths in protocol
// units and default timing for a 25 MHz system clock.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5,
        ST_GUARD      = 3'd6
    } ir_state_e;

    // Phase lengths in NEC units (one unit = 562.5 us)
    localparam int LEAD_MARK_U      = 16;
    localparam int LEAD_SPACE_U     = 8;
    localparam int REPEAT_SPACE_U   = 4;
    localparam int BIT_MARK_U       = 1;
    localparam int BIT_ZERO_SPACE_U = 1;
    localparam int BIT_ONE_SPACE_U  = 3;
    localparam int STOP_MARK_U      = 1;
    localparam int FRAME_UNITS      = 192;
    localparam int NEC_BITS         = 32;

    // Defaults for a 25 MHz clock
    localparam int DEF_UNIT_CYCLES  = 14063;
    localparam int DEF_CARRIER_HALF = 329;

    // Length in units of the phase a state represents. Leader space is
    // shorter for repeat frames; bit space length carries the bit value.
    function automatic logic [4:0] phase_units(input ir_state_e s,
                                               input logic      rep,
                                               input logic      bit_val);
        logic [4:0] n;
        case (s)
            ST_LEAD_MARK:  n = 5'(LEAD_MARK_U);
            ST_LEAD_SPACE: n = rep ? 5'(REPEAT_SPACE_U) : 5'(LEAD_SPACE_U);
            ST_BIT_MARK:   n = 5'(BIT_MARK_U);
            ST_BIT_SPACE:  n = bit_val ? 5'(BIT_ONE_SPACE_U) : 5'(BIT_ZERO_SPACE_U);
            ST_STOP_MARK:  n = 5'(STOP_MARK_U);
            default:       n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ir_encoder_carrier_gen.sv
// Carrier generator for the IR LED drive. A restart pulse forces the carrier
// high with a fresh phase count so every mark opens with a full high
// half-period; while run is held the carrier toggles every CARRIER_HALF
// clocks; otherwise it is parked low.
module ir_carrier_gen
    import ir_nec_pkg::*;
#(
    parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic carrier
);

    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_carrier;

    // Half-period counter and carrier level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end else if (restart) begin
            r_cnt     <= '0;
            r_carrier <= 1'b1;
        end else if (run) begin
            if (r_cnt == HALF_LAST) begin
                r_cnt     <= '0;
                r_carrier <= ~r_carrier;
            end else begin
                r_cnt     <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end
    end

    assign carrier = r_carrier;

endmodule

// File: rtl/ir_encoder.sv
// NEC infrared transmitter. Serialises a 32-bit command (LSB first) or a
// repeat frame into the NEC mark/space envelope, padded to a fixed 108 ms
// frame period, and drives an optionally 38 kHz-modulated LED output.
module ir_encoder
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYCLES  = DEF_UNIT_CYCLES,
    parameter int CARRIER_HALF = DEF_CARRIER_HALF,
    parameter bit MODULATE     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        repeat_req,
    input  logic [31:0] command,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_rx_level,
    output logic        ir_out
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYCLES - 1);
    localparam logic [7:0]    FRAME_LAST = 8'(FRAME_UNITS - 1);
    localparam logic [5:0]    BITS_LAST  = 6'(NEC_BITS - 1);

    ir_state_e   r_state;
    logic [UW-1:0] r_cyc;      // clock within the current unit
    logic [4:0]  r_ph;         // units elapsed in the current phase
    logic [7:0]  r_frame;      // units elapsed since the first leader cycle
    logic [5:0]  r_bit;        // data bits already sent
    logic [31:0] r_shift;
    logic        r_repeat;
    logic        r_busy;
    logic        r_done;
    logic        r_env;
    logic        r_rx;

    logic        w_unit_end;
    logic        w_phase_end;
    logic [4:0]  w_ph_len;
    logic        w_enter_mark;
    logic        w_carrier_run;
    logic        w_carrier;

    // Phase timing decode and carrier control derived from the FSM state
    always_comb begin
        w_unit_end  = (r_cyc == UNIT_LAST);
        w_ph_len    = phase_units(r_state, r_repeat, r_shift[0]);
        w_phase_end = 1'b0;
        if (r_state == ST_IDLE) begin
            w_phase_end = 1'b0;
        end else if (r_state == ST_GUARD) begin
            // The guard ends on the frame period, not on its own length
            w_phase_end = w_unit_end && (r_frame == FRAME_LAST);
        end else begin
            w_phase_end = w_unit_end && (r_ph == (w_ph_len - 5'd1));
        end

        // A mark is entered on accept and at the end of every space that
        // precedes one (leader space and bit space).
        w_enter_mark = 1'b0;
        if (!enable) begin
            w_enter_mark = 1'b0;
        end else if (r_state == ST_IDLE) begin
            w_enter_mark = start;
        end else if ((r_state == ST_LEAD_SPACE) || (r_state == ST_BIT_SPACE)) begin
            w_enter_mark = w_phase_end;
        end else begin
            w_enter_mark = 1'b0;
        end

        // Keep the carrier running only while the mark continues next cycle
        w_carrier_run = r_env && enable && !w_phase_end;
    end

    // Frame sequencer: state, unit timebase, payload shifter and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cyc    <= '0;
            r_ph     <= 5'd0;
            r_frame  <= 8'd0;
            r_bit    <= 6'd0;
            r_shift  <= 32'd0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_env    <= 1'b0;
            r_rx     <= 1'b1;
        end else if ((r_state != ST_IDLE) && !enable) begin
            // Abort: drop straight to idle without signalling completion
            r_state  <= ST_IDLE;
            r_cyc    <= '0;
            r_ph     <= 5'd0;
            r_frame  <= 8'd0;
            r_bit    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_env    <= 1'b0;
            r_rx     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE) begin
                if (w_unit_end) begin
                    r_cyc   <= '0;
                    r_frame <= r_frame + 8'd1;
                end else begin
                    r_cyc   <= r_cyc + UW'(1);
                end
                if (w_phase_end) begin
                    r_ph <= 5'd0;
                end else if (w_unit_end) begin
                    r_ph <= r_ph + 5'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && enable) begin
                        r_shift  <= command;
                        r_repeat <= repeat_req;
                        r_bit    <= 6'd0;
                        r_cyc    <= '0;
                        r_ph     <= 5'd0;
                        r_frame  <= 8'd0;
                        r_state  <= ST_LEAD_MARK;
                        r_busy   <= 1'b1;
                        r_env    <= 1'b1;
                        r_rx     <= 1'b0;
                    end
                end
                ST_LEAD_MARK: begin
                    if (w_phase_end) begin
                        r_state <= ST_LEAD_SPACE;
                        r_env   <= 1'b0;
                        r_rx    <= 1'b1;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (w_phase_end) begin
                        r_state <= r_repeat ? ST_STOP_MARK : ST_BIT_MARK;
                        r_env   <= 1'b1;
                        r_rx    <= 1'b0;
                    end
                end
                ST_BIT_MARK: begin
                    if (w_phase_end) begin
                        r_state <= ST_BIT_SPACE;
                        r_env   <= 1'b0;
                        r_rx    <= 1'b1;
                    end
                end
                ST_BIT_SPACE: begin
                    if (w_phase_end) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 6'd1;
                        r_state <= (r_bit == BITS_LAST) ? ST_STOP_MARK : ST_BIT_MARK;
                        r_env   <= 1'b1;
                        r_rx    <= 1'b0;
                    end
                end
                ST_STOP_MARK: begin
                    if (w_phase_end) begin
                        r_state <= ST_GUARD;
                        r_env   <= 1'b0;
                        r_rx    <= 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (w_phase_end) begin
                        r_state <= ST_IDLE;
                        r_cyc   <= '0;
                        r_ph    <= 5'd0;
                        r_frame <= 8'd0;
                        r_bit   <= 6'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_env   <= 1'b0;
                    r_rx    <= 1'b1;
                end
            endcase
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (w_enter_mark),
        .run     (w_carrier_run),
        .carrier (w_carrier)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign ir_env      = r_env;
    assign ir_rx_level = r_rx;
    assign ir_out      = MODULATE ? w_carrier : r_env;

endmodule

// File: tb/tb_ir_encoder.sv
// Self-checking bench for ir_encoder: a frame-level waveform model built
// from the NEC phase rules is compared with the DUT every cycle, plus
// hand-computed waveform points for directed frames.
module tb_ir_encoder;

    localparam int U  = 10;
    localparam int H  = 3;
    localparam int FL = 192 * U;

    logic        clk = 1'b0;
    logic        rst, enable, start, repeat_req;
    logic [31:0] command;
    logic        busy, done, ir_env, ir_rx_level, ir_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: expected envelope of one whole frame period
    bit m_env [0:FL-1];
    int m_off [0:FL-1];
    int m_pos  = -1;
    bit m_done = 1'b0;

    // Inputs as seen by the DUT at the last rising edge
    bit          s_valid = 1'b0;
    logic        s_rst, s_en, s_start, s_rep;
    logic [31:0] s_cmd;

    // Captured DUT outputs of a directed frame, indexed by frame offset
    logic cap_env  [0:FL+1];
    logic cap_busy [0:FL+1];
    logic cap_done [0:FL+1];
    logic cap_out  [0:FL+1];
    int   cap_ndone;

    ir_encoder #(
        .UNIT_CYCLES  (U),
        .CARRIER_HALF (H),
        .MODULATE     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .repeat_req  (repeat_req),
        .command     (command),
        .busy        (busy),
        .done        (done),
        .ir_env      (ir_env),
        .ir_rx_level (ir_rx_level),
        .ir_out      (ir_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void put_mark(input int u0, input int n);
        for (int k = 0; k < n * U; k++) begin
            m_env[u0 * U + k] = 1'b1;
            m_off[u0 * U + k] = k;
        end
    endfunction

    // Lay out the frame: 16u leader, 8u/4u space, 32 bits (1u mark + 1u/3u
    // space) for data frames, 1u stop mark, silence to the 192u period.
    function automatic void build(input logic [31:0] cmd, input bit rep);
        int u;
        for (int i = 0; i < FL; i++) begin
            m_env[i] = 1'b0;
            m_off[i] = 0;
        end
        put_mark(0, 16);
        u = 16 + (rep ? 4 : 8);
        if (!rep) begin
            for (int b = 0; b < 32; b++) begin
                put_mark(u, 1);
                u += 1 + (cmd[b] ? 3 : 1);
            end
        end
        put_mark(u, 1);
    endfunction

    always @(posedge clk) begin
        s_valid <= 1'b1;
        s_rst   <= rst;
        s_en    <= enable;
        s_start <= start;
        s_rep   <= repeat_req;
        s_cmd   <= command;
    end

    // Advance the model by one clock and compare every output
    always @(negedge clk) begin
        bit e_env, e_out;
        if (s_valid) begin
            if (s_rst) begin
                m_pos = -1; m_done = 1'b0;
            end else if (m_pos >= 0 && !s_en) begin
                m_pos = -1; m_done = 1'b0;
            end else if (m_pos < 0) begin
                m_done = 1'b0;
                if (s_start && s_en) begin
                    build(s_cmd, s_rep);
                    m_pos = 0;
                end
            end else begin
                m_pos++;
                m_done = 1'b0;
                if (m_pos == FL) begin
                    m_pos = -1; m_done = 1'b1;
                end
            end
            e_env = (m_pos >= 0) ? m_env[m_pos] : 1'b0;
            e_out = e_env && (((m_off[(m_pos >= 0) ? m_pos : 0] / H) % 2) == 0);
            chk("busy", busy, (m_pos >= 0) ? 1 : 0);
            chk("done", done, m_done);
            chk("ir_env", ir_env, e_env);
            chk("ir_rx_level", ir_rx_level, !e_env);
            chk("ir_out", ir_out, e_out);
        end
    end

    // Start a frame, then capture ncap+1 cycles of outputs by frame offset.
    // Optionally pulse start at pulse_at, and hold start from hold_from
    // across the done cycle with a follow-up command.
    task automatic send_frame(input logic [31:0] cmd, input bit rep, input int ncap,
                              input int pulse_at, input int hold_from,
                              input logic [31:0] next_cmd);
        @(negedge clk);
        command = cmd; repeat_req = rep; start = 1'b1;
        @(negedge clk);
        start = 1'b0; command = $urandom; repeat_req = 1'($urandom_range(0, 1));
        cap_ndone = 0;
        for (int t = 0; t <= ncap; t++) begin
            if (t > 0) @(negedge clk);
            cap_env[t] = ir_env; cap_busy[t] = busy; cap_done[t] = done; cap_out[t] = ir_out;
            if (done === 1'b1) cap_ndone++;
            if (t == pulse_at) start = 1'b1;
            if (t == pulse_at + 1) start = 1'b0;
            if (t == hold_from) begin
                start = 1'b1; command = next_cmd; repeat_req = 1'b0;
            end
            if (t == hold_from + 2) start = 1'b0;
        end
    endtask

    initial begin
        int len, drop_at, pulse_at, nd;
        rst = 1'b1; enable = 1'b1; start = 1'b0; repeat_req = 1'b0; command = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_env", ir_env, 0);
        chk("rst_rx", ir_rx_level, 1);
        chk("rst_out", ir_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Data frame 0x00FFA25D: 0x5D LSB first gives bits 1,0,1,...
        send_frame(32'h00FF_A25D, 1'b0, FL + 1, -5, -5, 32'd0);
        chk("A_env0", cap_env[0], 1);     chk("A_env159", cap_env[159], 1);
        chk("A_env160", cap_env[160], 0); chk("A_env239", cap_env[239], 0);
        chk("A_env240", cap_env[240], 1); chk("A_env249", cap_env[249], 1);
        chk("A_env250", cap_env[250], 0); chk("A_env279", cap_env[279], 0);
        chk("A_env280", cap_env[280], 1); chk("A_env290", cap_env[290], 0);
        chk("A_env300", cap_env[300], 1); chk("A_env1209", cap_env[1209], 1);
        chk("A_env1210", cap_env[1210], 0);
        chk("A_out0", cap_out[0], 1);     chk("A_out2", cap_out[2], 1);
        chk("A_out3", cap_out[3], 0);     chk("A_out6", cap_out[6], 1);
        chk("A_out160", cap_out[160], 0);
        chk("A_busy0", cap_busy[0], 1);   chk("A_busy1919", cap_busy[1919], 1);
        chk("A_busy1920", cap_busy[1920], 0);
        chk("A_done1919", cap_done[1919], 0); chk("A_done1920", cap_done[1920], 1);
        chk("A_ndone", cap_ndone, 1);
        #1;
        chk("model_env159", m_env[159], 1); chk("model_env160", m_env[160], 0);
        chk("model_env250", m_env[250], 0); chk("model_env280", m_env[280], 1);
        chk("model_off249", m_off[249], 9);

        // Repeat frame: 160 high, 40 low, 10 high, then silence
        send_frame(32'hFFFF_FFFF, 1'b1, FL + 1, -5, -5, 32'd0);
        chk("B_env159", cap_env[159], 1); chk("B_env160", cap_env[160], 0);
        chk("B_env199", cap_env[199], 0); chk("B_env200", cap_env[200], 1);
        chk("B_env209", cap_env[209], 1); chk("B_env210", cap_env[210], 0);
        chk("B_env1000", cap_env[1000], 0);
        chk("B_busy1919", cap_busy[1919], 1); chk("B_done1920", cap_done[1920], 1);
        chk("B_ndone", cap_ndone, 1);

        // All-zero command, start pulsed mid-frame, start held through done
        send_frame(32'd0, 1'b0, FL + 1, 500, FL - 1, $urandom);
        chk("C_env889", cap_env[889], 1); chk("C_env890", cap_env[890], 0);
        chk("C_env900", cap_env[900], 0);
        chk("C_done1920", cap_done[1920], 1);
        chk("C_b2b_env", cap_env[FL + 1], 1); chk("C_b2b_busy", cap_busy[FL + 1], 1);
        chk("C_b2b_out", cap_out[FL + 1], 1);
        repeat (FL + 4) @(negedge clk);

        // Abort during the first bit space; no done may follow
        send_frame($urandom | 32'd1, 1'b0, 250, -5, -5, 32'd0);
        chk("D_pre_env", cap_env[250], 0); chk("D_pre_busy", cap_busy[250], 1);
        enable = 1'b0;
        @(negedge clk);
        chk("D_busy", busy, 0); chk("D_env", ir_env, 0);
        chk("D_out", ir_out, 0); chk("D_done", done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; enable = 1'b1;
        nd = 0;
        for (int c = 0; c < FL + 50; c++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("D_no_done", nd, 0);

        // Reset in the middle of a frame
        send_frame($urandom, 1'b0, 700, -5, -5, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("E_busy", busy, 0); chk("E_env", ir_env, 0);
        chk("E_rx", ir_rx_level, 1); chk("E_out", ir_out, 0);
        rst = 1'b0;

        // Random frames with random aborts and stray start pulses
        for (int f = 0; f < 8; f++) begin
            @(negedge clk);
            command = $urandom; repeat_req = ($urandom_range(0, 3) == 0); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            len      = $urandom_range(1500, 2100);
            drop_at  = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 1900) : -10;
            pulse_at = $urandom_range(0, 2000);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                command    = $urandom;
                repeat_req = 1'($urandom_range(0, 1));
                enable     = (c == drop_at) ? 1'b0 : 1'b1;
                start      = (c == pulse_at) ? 1'b1 : 1'b0;
            end
            enable = 1'b1; start = 1'b0;
            repeat (FL + 5) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
